// File: rtl/uart_pkg.sv
// Shared types, parity-mode constants and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per serial bit, truncated toward zero.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Parity bit for a frame. Narrow words are zero-extended, which leaves
  // the XOR reduction unchanged. Even mode makes the total count of ones
  // even, odd mode makes it odd.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: Tick pulses for one clock on the last clock of every
// DIV-clock period, with the period boundary realigned by Restart.
module uart_baud_tick import uart_pkg::*; #(
  parameter int DIV = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Restart,
  output logic Tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  // Count clocks within the current bit period; Restart starts a fresh period at 0
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (Restart || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign Tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one word per XMitGo/TxEmpty handshake and shifts
// it out as start bit, data bits LSB first, optional parity and stop bit(s).
// Tx and TxEmpty are both registered so the pin never sees a glitch.
module uart_tx_serializer import uart_pkg::*; #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 XMitGo,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 TxEmpty,
  output logic                 Tx
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (DIV < 2) begin : g_checkDiv
    $error("uart_tx_serializer: CLK_HZ/BAUD must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_checkDataBits
    $error("uart_tx_serializer: DATA_BITS must be 5..8");
  end
  if ((PARITY < PAR_NONE) || (PARITY > PAR_EVEN)) begin : g_checkParity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_checkStopBits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  tx_state_t              r_state;
  tx_state_t              w_stateNext;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shiftNext;
  logic [2:0]             r_bitCnt;
  logic [2:0]             w_bitCntNext;
  logic                   r_parityBit;
  logic                   w_parityNext;
  logic                   r_tx;
  logic                   r_txEmpty;
  logic                   w_txNext;
  logic                   w_accept;
  logic                   w_tick;

  assign w_accept = (r_state == S_IDLE) && XMitGo;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud (
    .Clock  (Clock),
    .Reset  (Reset),
    .Restart(w_accept),
    .Tick   (w_tick)
  );

  // Frame sequencing: advance one bit at the end of each bit period
  always_comb begin
    w_stateNext  = r_state;
    w_shiftNext  = r_shift;
    w_bitCntNext = r_bitCnt;
    w_parityNext = r_parityBit;
    unique case (r_state)
      S_IDLE: begin
        if (XMitGo) begin
          w_stateNext  = S_START;
          w_shiftNext  = TxData;
          w_bitCntNext = '0;
          w_parityNext = parity_bit(8'(TxData), PARITY);
        end
      end
      S_START: begin
        if (w_tick) begin
          w_stateNext  = S_DATA;
          w_bitCntNext = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bitCnt == LAST_DATA) begin
            w_stateNext  = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            w_bitCntNext = '0;
          end else begin
            w_shiftNext  = {1'b0, r_shift[DATA_BITS-1:1]};
            w_bitCntNext = r_bitCnt + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_stateNext  = S_STOP;
          w_bitCntNext = '0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bitCnt == LAST_STOP) begin
            w_stateNext  = S_IDLE;
            w_bitCntNext = '0;
          end else begin
            w_bitCntNext = r_bitCnt + 3'd1;
          end
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Line level for the coming clock, derived from where the frame is heading
  always_comb begin
    w_txNext = 1'b1;
    unique case (w_stateNext)
      S_START:  w_txNext = 1'b0;
      S_DATA:   w_txNext = w_shiftNext[0];
      S_PARITY: w_txNext = w_parityNext;
      default:  w_txNext = 1'b1;
    endcase
  end

  // State register; reset abandons any frame in flight
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Datapath and registered outputs; the line goes high at once on reset
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_parityBit <= 1'b0;
      r_tx        <= 1'b1;
      r_txEmpty   <= 1'b1;
    end else begin
      r_shift     <= w_shiftNext;
      r_bitCnt    <= w_bitCntNext;
      r_parityBit <= w_parityNext;
      r_tx        <= w_txNext;
      r_txEmpty   <= (w_stateNext == S_IDLE);
    end
  end

  assign Tx      = r_tx;
  assign TxEmpty = r_txEmpty;

endmodule
